mdio_arbiter: RTL

- Shares one MDIO management-frame generator (the MDIO master/PHY-access path) among NREQ requesters.
- Each requester presents a complete 32-bit management frame. The block picks one with round-robin arbitration, validates it, and launches it on the generator.
- It waits for the generator's completion, then returns read data and a per-requester DONE pulse.
- It sits between on-chip management clients (link monitor, config loader, debug port) and the MDIO generator/receptor pair.

---
 rtl/mdio_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/mdio_arbiter.sv
// Round-robin arbiter sharing one MDIO frame generator among NREQ requesters.
// Optional WAIT-state abort enabled by defining MDIO_TIMEOUT_EN.
module mdio_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 80
) (
    input  logic                 MDC,
    input  logic                 RESET,
    input  logic [NREQ-1:0]      REQ,
    input  logic [32*NREQ-1:0]   REQ_FRAME,
    output logic [NREQ-1:0]      GNT,
    output logic [NREQ-1:0]      DONE,
    output logic                 ERR,
    output logic [15:0]          RD_DATA,
    output logic [31:0]          T_DATA,
    output logic                 MDIO_START,
    input  logic [15:0]          RD_DATA_IN,
    input  logic                 DATA_RDY
);

    localparam int unsigned IW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_bad_cfg
        $error("mdio_arbiter: unsupported NREQ/TIMEOUT");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   last_q;
    logic [IW-1:0]   gnt_idx_q;
    logic [IW-1:0]   pick_idx;
    logic [IW-1:0]   cand;
    logic            pick_vld;
    logic [31:0]     pick_frame;
    logic            frame_ok;
    logic            err_q, err_nxt;
    logic            wait_abort;
    logic [NREQ-1:0] gnt_onehot;

    // Descending scan so the candidate nearest to last+1 is the one left standing.
    always_comb begin
        pick_vld   = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        pick_frame = '0;
        for (int unsigned k = NREQ; k > 0; k--) begin
            cand = IW'((32'(last_q) + k) % NREQ);
            if (REQ[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick_idx == IW'(i)) begin
                pick_frame = REQ_FRAME[32*i +: 32];
            end
        end
        frame_ok = (pick_frame[31:30] == 2'b01) &&
                   ((pick_frame[29:28] == 2'b01) || (pick_frame[29:28] == 2'b10));
    end

`ifdef MDIO_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] to_cnt;

    always_ff @(posedge MDC or negedge RESET) begin
        if (!RESET) begin
            to_cnt <= '0;
        end else if (state != ST_WAIT) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    assign wait_abort = (to_cnt == TO_LAST);
`else
    assign wait_abort = 1'b0;
`endif

    always_comb begin
        state_nxt  = state;
        err_nxt    = err_q;
        gnt_onehot = {{(NREQ-1){1'b0}}, 1'b1} << gnt_idx_q;
        GNT        = '0;
        DONE       = '0;
        ERR        = 1'b0;
        MDIO_START = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_vld) begin
                    state_nxt = frame_ok ? ST_ISSUE : ST_RESP;
                    err_nxt   = !frame_ok;
                end
            end
            ST_ISSUE: begin
                GNT        = gnt_onehot;
                MDIO_START = 1'b1;
                state_nxt  = ST_WAIT;
            end
            ST_WAIT: begin
                GNT = gnt_onehot;
                if (DATA_RDY) begin
                    state_nxt = ST_RESP;
                    err_nxt   = 1'b0;
                end else if (wait_abort) begin
                    state_nxt = ST_RESP;
                    err_nxt   = 1'b1;
                end
            end
            ST_RESP: begin
                GNT       = gnt_onehot;
                DONE      = gnt_onehot;
                ERR       = err_q;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge MDC or negedge RESET) begin
        if (!RESET) begin
            state     <= ST_IDLE;
            last_q    <= IW'(NREQ - 1);
            gnt_idx_q <= '0;
            err_q     <= 1'b0;
            T_DATA    <= '0;
            RD_DATA   <= '0;
        end else begin
            state <= state_nxt;
            err_q <= err_nxt;
            if (state == ST_IDLE && pick_vld) begin
                gnt_idx_q <= pick_idx;
                T_DATA    <= pick_frame;
            end
            if (state == ST_WAIT && DATA_RDY && T_DATA[29:28] == 2'b10) begin
                RD_DATA <= RD_DATA_IN;
            end
            if (state == ST_RESP) begin
                last_q <= gnt_idx_q;
            end
        end
    end

endmodule
